seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_pkg.sv | 26 ++
 rtl/seg_hex_decoder.sv | 17 +
 rtl/seg_scan_driver.sv | 138 +++++++++++++
 tb/tb_seg_scan_driver.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the seven-segment scan driver: digit count, the
// active-low hex glyph table and the all-segments-off pattern.
// Segment bit order is {DP,G,F,E,D,C,B,A}, active low. DP is off (1) in
// every glyph.
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Entry 15 is the leftmost byte, entry 0 the rightmost.
    localparam logic [15:0][7:0] GLYPH_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
        8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

    function automatic logic [7:0] glyph_of(input logic [3:0] nibble);
        return GLYPH_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// -----------------------------------------------------------------------------
// seg_hex_decoder
// Purely combinational hex-to-seven-segment lookup.
// Ports:
//   nibble : in,  4 bits - hex digit to show
//   glyph  : out, 8 bits - active-low segments {DP,G,F,E,D,C,B,A}
// -----------------------------------------------------------------------------
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] glyph
);

    assign glyph = glyph_of(nibble);

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// A divide counter holds each digit lit for SCAN_DIV clocks; a new value is
// only ever latched into the display register at the start of a frame so a
// frame never shows a mix of two values.
//
// Parameters:
//   SCAN_DIV     : clk_i cycles each digit stays lit (>= 2)
// Ports:
//   clk_i        : in,  1 bit  - clock, rising edge
//   rst_i        : in,  1 bit  - asynchronous active-high reset
//   data_i       : in,  32 bits - value to display
//   data_vld_i   : in,  1 bit  - one-cycle strobe offering data_i
//   led_en_o     : out, 8 bits - active-low digit enables, bit k = digit k
//   led_seg_o    : out, 8 bits - active-low segments {DP,G,F,E,D,C,B,A}
//   frame_done_o : out, 1 bit  - one-cycle pulse when the scan wraps to digit 0
//
// Build option:
//   SEG_BLANK_LZ_EN - when defined, leading-zero digits (k>0 with nibbles k..7
//                     all zero) are blanked; digit 0 is always shown.
// -----------------------------------------------------------------------------
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 20000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic        data_vld_i,
    output logic [7:0]  led_en_o,
    output logic [7:0]  led_seg_o,
    output logic        frame_done_o
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0] div_cnt;
    logic [IDX_W-1:0] digit_idx;
    logic [IDX_W-1:0] next_idx;
    logic [31:0]      shadow;
    logic [31:0]      hold;
    logic [31:0]      next_hold;
    logic             pending;
    logic             tick;
    logic             wrap;
    logic [3:0]       cur_nibble;
    logic [7:0]       raw_glyph;
    logic [7:0]       disp_glyph;

    assign tick     = (div_cnt == CNT_W'(SCAN_DIV - 1));
    assign next_idx = digit_idx + IDX_W'(1);
    assign wrap     = tick && (digit_idx == IDX_W'(NUM_DIGITS - 1));

    // The value digit 0 must show on a wrap tick is the one being loaded in
    // that same cycle, so decode from the look-ahead register value.
    // A strobe landing exactly on the wrap tick beats the older shadow copy.
    always_comb begin
        next_hold = hold;
        if (wrap) begin
            if (data_vld_i) begin
                next_hold = data_i;
            end else if (pending) begin
                next_hold = shadow;
            end
        end
    end

    assign cur_nibble = next_hold[{next_idx, 2'b00} +: 4];

    seg_hex_decoder u_decoder (
        .nibble (cur_nibble),
        .glyph  (raw_glyph)
    );

`ifdef SEG_BLANK_LZ_EN
    // Digit k is a leading zero when every nibble from k upward is zero.
    logic lead_zero;
    assign lead_zero  = (next_idx != '0) && ((next_hold >> {next_idx, 2'b00}) == 32'd0);
    assign disp_glyph = lead_zero ? SEG_BLANK : {1'b1, raw_glyph[6:0]};
`else
    assign disp_glyph = {1'b1, raw_glyph[6:0]};
`endif

    // Digit dwell counter; tick is its terminal count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    // Index resets to the last digit so the very first tick is a wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            digit_idx <= IDX_W'(NUM_DIGITS - 1);
        end else if (tick) begin
            digit_idx <= next_idx;
        end
    end

    // Strobes outside the wrap tick park in the shadow; the last one wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow  <= '0;
            hold    <= '0;
            pending <= 1'b0;
        end else begin
            hold <= next_hold;
            if (wrap) begin
                pending <= 1'b0;
            end else if (data_vld_i) begin
                shadow  <= data_i;
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            led_en_o     <= '1;
            led_seg_o    <= SEG_BLANK;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= wrap;
            if (tick) begin
                led_en_o  <= ~(8'h01 << next_idx);
                led_seg_o <= disp_glyph;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
// Self-checking bench for seg_scan_driver with SCAN_DIV=4. A reference model
// tracks elapsed cycles since reset release and derives which digit is lit
// from plain arithmetic, plus the value/pending bookkeeping. Every cycle is
// compared against the model; table vectors and hand sequences add explicit
// constant checks for the notable corner cases.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [31:0] data;
    logic [7:0]  led_en;
    logic [7:0]  led_seg;
    logic        fd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.SCAN_DIV(D)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_i       (data),
        .data_vld_i   (vld),
        .led_en_o     (led_en),
        .led_seg_o    (led_seg),
        .frame_done_o (fd)
    );

    // Glyph list as written in the display requirements, index = hex digit.
    logic [7:0] glyph_ref [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model state
    logic [31:0] m_hold;
    logic [31:0] m_shadow;
    bit          m_pend;
    logic [7:0]  m_en;
    logic [7:0]  m_seg;
    logic        m_fd;
    int          n;
    int          last_digit;

    typedef struct {
        logic [31:0] value;
        logic [7:0]  d0;
        logic [7:0]  d7;
    } vec_t;

    vec_t vecs [4];

    function automatic logic [7:0] ref_seg(input logic [31:0] v, input int k);
`ifdef SEG_BLANK_LZ_EN
        if (k > 0 && (v >> (4 * k)) == 32'd0) return 8'hFF;
`endif
        return glyph_ref[v[4*k +: 4]];
    endfunction

    task automatic modelReset();
        m_hold     = '0;
        m_shadow   = '0;
        m_pend     = 0;
        m_en       = 8'hFF;
        m_seg      = 8'hFF;
        m_fd       = 1'b0;
        n          = 0;
        last_digit = -1;
    endtask

    // Edge number n (counted from reset release) ends a dwell when
    // n mod D == D-1; that dwell's ordinal picks the digit.
    task automatic modelEdge(input bit v, input logic [31:0] d);
        bit tk;
        bit wr;
        int k;
        tk = (n % D) == D - 1;
        k  = (n / D) % 8;
        wr = tk && (k == 0);
        if (wr) begin
            if (v) m_hold = d;
            else if (m_pend) m_hold = m_shadow;
            m_pend = 0;
        end else if (v) begin
            m_shadow = d;
            m_pend   = 1;
        end
        m_fd       = wr;
        last_digit = -1;
        if (tk) begin
            m_en       = ~(8'h01 << k);
            m_seg      = ref_seg(m_hold, k);
            last_digit = k;
        end
        n++;
    endtask

    function automatic bit nextIsWrap();
        return ((n % D) == D - 1) && (((n / D) % 8) == 0);
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue($sformatf("%s en n=%0d", tag, n), {24'd0, led_en}, {24'd0, m_en});
        checkValue($sformatf("%s seg n=%0d", tag, n), {24'd0, led_seg}, {24'd0, m_seg});
        checkValue($sformatf("%s frame_done n=%0d", tag, n), {31'd0, fd}, {31'd0, m_fd});
    endtask

    // One clock: drive at the falling edge, check 1ns after the rising edge.
    task automatic applyStimulus(input bit v, input logic [31:0] d);
        vld  = v;
        data = d;
        @(posedge clk);
        modelEdge(v, d);
        #1;
        checkOutput("cycle");
        @(negedge clk);
        vld  = 1'b0;
        data = '0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        vld = 1'b0;
        #1;
        modelReset();
        checkValue("reset en", {24'd0, led_en}, 32'hFF);
        checkValue("reset seg", {24'd0, led_seg}, 32'hFF);
        checkValue("reset frame_done", {31'd0, fd}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitDigit(input int k);
        for (int i = 0; i < 9 * D; i++) begin
            applyStimulus(0, '0);
            if (last_digit == k) return;
        end
        checkValue($sformatf("timeout waiting for digit %0d", k), 32'd0, 32'd1);
    endtask

    task automatic waitBeforeWrap();
        for (int i = 0; i < 9 * D; i++) begin
            if (nextIsWrap()) return;
            applyStimulus(0, '0);
        end
        checkValue("timeout waiting for wrap", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{value: 32'h12345678, d0: 8'h80, d7: 8'hF9};
        vecs[1] = '{value: 32'hA0B0C0D0, d0: 8'hC0, d7: 8'h88};
        vecs[2] = '{value: 32'hFEDCBA98, d0: 8'h80, d7: 8'h8E};
        vecs[3] = '{value: 32'h9ABCDEF1, d0: 8'hF9, d7: 8'h90};

        rst  = 1'b1;
        vld  = 1'b0;
        data = '0;
        doReset();

        // First tick lands SCAN_DIV cycles after release and is a wrap.
        for (int i = 0; i < D - 1; i++) applyStimulus(0, '0);
        applyStimulus(0, '0);
        checkValue("first tick en", {24'd0, led_en}, 32'hFE);
        checkValue("first tick seg", {24'd0, led_seg}, 32'hC0);
        checkValue("first tick frame_done", {31'd0, fd}, 32'd1);
        applyStimulus(0, '0);
        checkValue("frame_done one cycle", {31'd0, fd}, 32'd0);

        // Mid-frame strobes appear only at the next frame.
        foreach (vecs[i]) begin
            waitDigit(3);
            applyStimulus(1, vecs[i].value);
            waitDigit(0);
            checkValue($sformatf("vec%0d digit0", i), {24'd0, led_seg}, {24'd0, vecs[i].d0});
            waitDigit(7);
            checkValue($sformatf("vec%0d digit7", i), {24'd0, led_seg}, {24'd0, vecs[i].d7});
        end

        // Strobe on the wrap tick itself is shown immediately.
        waitBeforeWrap();
        applyStimulus(1, 32'hDEADBEEF);
        checkValue("wrap strobe digit0", {24'd0, led_seg}, 32'h8E);
        checkValue("wrap strobe en", {24'd0, led_en}, 32'hFE);
        waitDigit(1);
        checkValue("wrap strobe digit1", {24'd0, led_seg}, 32'h86);
        waitDigit(0);
        checkValue("no stale pending", {24'd0, led_seg}, 32'h8E);

        // Last strobe in a frame wins.
        waitDigit(2);
        applyStimulus(1, 32'h1);
        applyStimulus(1, 32'h2);
        waitDigit(0);
        checkValue("last strobe wins", {24'd0, led_seg}, 32'hA4);

        // Small value: leading digits blank or zero depending on build.
        waitDigit(4);
        applyStimulus(1, 32'h5);
        waitDigit(0);
        checkValue("small value digit0", {24'd0, led_seg}, 32'h92);
        waitDigit(1);
`ifdef SEG_BLANK_LZ_EN
        checkValue("small value digit1", {24'd0, led_seg}, 32'hFF);
`else
        checkValue("small value digit1", {24'd0, led_seg}, 32'hC0);
`endif
        waitDigit(7);
`ifdef SEG_BLANK_LZ_EN
        checkValue("small value digit7", {24'd0, led_seg}, 32'hFF);
`else
        checkValue("small value digit7", {24'd0, led_seg}, 32'hC0);
`endif

        // Reset during digit 3 drops both the shown value and pending data.
        waitDigit(2);
        applyStimulus(1, 32'hABCDEF12);
        waitDigit(3);
        doReset();
        waitDigit(0);
        checkValue("post reset digit0", {24'd0, led_seg}, 32'hC0);
        checkValue("post reset frame_done", {31'd0, fd}, 32'd1);

        // Random strobes, including values with leading zero nibbles.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                applyStimulus(1, $urandom >> $urandom_range(0, 31));
            end else begin
                applyStimulus(0, '0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
